// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: opcode and state encodings plus instruction field layout shared by the core and ALU
package cpu_core_pkg;

    localparam int OP_MSB = 2;
    localparam int OP_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_JMP, OP_HALT
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_FETCH_A, ST_FETCH_B, ST_FETCH_D,
        ST_LOAD_A, ST_LOAD_B, ST_EXEC, ST_STORE, ST_HALTED
    } state_t;

    function automatic logic is_access(state_t s);
        return s inside {ST_FETCH, ST_FETCH_A, ST_FETCH_B, ST_FETCH_D, ST_LOAD_A, ST_LOAD_B, ST_STORE};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU producing result, zero and signed-overflow flags
module cpu_alu
    import cpu_core_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  op_t                  op,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero,
    output logic                 ovf
);

    localparam int M = WORD_SIZE - 1;

    // result per opcode; overflow only meaningful for ADD/SUB, cleared otherwise
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = a + b;
                ovf    = (a[M] == b[M]) && (result[M] != a[M]);
            end
            OP_SUB: begin
                result = a - b;
                ovf    = (a[M] != b[M]) && (result[M] != a[M]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
        zero = result == '0;
    end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multicycle direct-addressing CPU with req/ack memory port, JMP/HALT and start pulse
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int RST_PC    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 halted,
    output logic                 flag_zero,
    output logic                 flag_ovf
);

    state_t               state, state_nxt;
    op_t                  op;
    logic [ADDR_SIZE-1:0] pc, a_addr, b_addr, d_addr;
    logic [WORD_SIZE-1:0] a, b, result;
    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_zero, alu_ovf;
    logic                 acc;
    op_t                  fetched;
    logic [ADDR_SIZE-1:0] rd_addr, pc_inc;

    assign acc     = mem_req & mem_ack;
    assign fetched = op_t'(mem_rdata[OP_MSB:OP_LSB]);
    assign rd_addr = mem_rdata[ADDR_SIZE-1:0];
    assign pc_inc  = pc + ADDR_SIZE'(1);

    cpu_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (alu_result),
        .zero   (alu_zero),
        .ovf    (alu_ovf)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state: access states advance only on an accepted handshake
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALTED: state_nxt = start ? ST_FETCH : state;
            ST_FETCH:   if (acc) state_nxt = fetched == OP_NOP ? ST_FETCH : fetched == OP_HALT ? ST_HALTED : ST_FETCH_A;
            ST_FETCH_A: if (acc) state_nxt = op == OP_JMP ? ST_FETCH : ST_FETCH_B;
            ST_FETCH_B: if (acc) state_nxt = ST_FETCH_D;
            ST_FETCH_D: if (acc) state_nxt = ST_LOAD_A;
            ST_LOAD_A:  if (acc) state_nxt = ST_LOAD_B;
            ST_LOAD_B:  if (acc) state_nxt = ST_EXEC;
            ST_EXEC:    state_nxt = ST_STORE;
            ST_STORE:   if (acc) state_nxt = ST_FETCH;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // memory port and status decoded from state so reset drops the request on the next edge
    always_comb begin
        mem_req = is_access(state);
        mem_we  = state == ST_STORE;
        case (state)
            ST_FETCH, ST_FETCH_A, ST_FETCH_B, ST_FETCH_D: mem_addr = pc;
            ST_LOAD_A: mem_addr = a_addr;
            ST_LOAD_B: mem_addr = b_addr;
            ST_STORE:  mem_addr = d_addr;
            default:   mem_addr = '0;
        endcase
        mem_wdata = mem_we ? result : '0;
        busy      = !(state inside {ST_IDLE, ST_HALTED});
        halted    = state == ST_HALTED;
    end

    // datapath: pc, operand addresses, operands, result and flags captured on accepting edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= ADDR_SIZE'(RST_PC);
            op        <= OP_NOP;
            a_addr    <= '0;
            b_addr    <= '0;
            d_addr    <= '0;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: if (acc) begin
                    pc <= pc_inc;
                    op <= fetched;
                end
                ST_FETCH_A: if (acc) begin
                    pc     <= op == OP_JMP ? rd_addr : pc_inc;
                    a_addr <= rd_addr;
                end
                ST_FETCH_B: if (acc) begin
                    pc     <= pc_inc;
                    b_addr <= rd_addr;
                end
                ST_FETCH_D: if (acc) begin
                    pc     <= pc_inc;
                    d_addr <= rd_addr;
                end
                ST_LOAD_A: if (acc) a <= mem_rdata;
                ST_LOAD_B: if (acc) b <= mem_rdata;
                ST_EXEC: begin
                    result    <= alu_result;
                    flag_zero <= alu_zero;
                    flag_ovf  <= alu_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed self-checking bench for cpu_core with RST_PC=0xFE and an optional wait-state memory
module tb_cpu_core;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_req, mem_we, mem_ack;
    logic       busy, halted, flag_zero, flag_ovf;

    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h0, ld_data = 8'h0;
    logic       wait_mode = 1'b0, we_block = 1'b0;
    logic [1:0] cnt = 2'd0;
    int         cyc = 0, store_cyc = 0, t0 = 0;
    int         vectors = 0, miscompares = 0;
    logic       pend = 1'b0, stab_err = 1'b0;
    int         stab_cnt = 0;
    logic [7:0] p_addr = 8'h0, p_wdata = 8'h0;
    logic       p_we = 1'b0;
    logic       ok;

    cpu_core #(.WORD_SIZE(8), .ADDR_SIZE(8), .RST_PC(8'hFE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .halted    (halted),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (cnt == 2'd0) && !(we_block && mem_we);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_req && mem_we && mem_ack) begin
            mem[mem_addr] <= mem_wdata;
            store_cyc     <= cyc + 1;
        end
        if (mem_req && mem_ack) cnt <= wait_mode ? 2'($urandom_range(3, 0)) : 2'd0;
        else if (mem_req && cnt != 2'd0) cnt <= cnt - 2'd1;
    end

    always @(negedge clk) begin
        if (pend) begin
            stab_cnt <= stab_cnt + 1;
            if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) stab_err <= 1'b1;
        end
        pend    <= rst_n && mem_req && !mem_ack;
        p_addr  <= mem_addr;
        p_we    <= mem_we;
        p_wdata <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        ld_addr = addr;
        ld_data = data;
        ld_en   = 1'b1;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_halt(input int lim, output logic done);
        done = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (halted) begin
                done = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        step();
        chk("rst_with_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_flags", 32'({flag_zero, flag_ovf}), 32'd0);
        chk("rst_pc", 32'(dut.pc), 32'hFE);

        // zero-wait ADD wrapping across 0xFF->0x00 mid-instruction, HALT after it
        poke(8'hFE, 8'd1); poke(8'hFF, 8'd10); poke(8'h00, 8'd11); poke(8'h01, 8'd12); poke(8'h02, 8'd7);
        poke(8'd10, 8'h05); poke(8'd11, 8'h03); poke(8'd12, 8'h00);
        go();
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_first_fetch", 32'(mem_addr), 32'hFE);
        wait_halt(40, ok);
        chk("add_halt_reached", 32'(ok), 32'd1);
        chk("add_result", 32'(mem[12]), 32'h08);
        chk("add_flags", 32'({flag_zero, flag_ovf}), 32'd0);
        chk("add_store_latency", 32'(store_cyc - t0), 32'd8);
        chk("add_halt_pc", 32'(dut.pc), 32'h03);

        // ADD overflow, SUB overflow, XOR zero, continued from successive starts
        do_reset();
        poke(8'hFE, 8'd1); poke(8'hFF, 8'h30); poke(8'h00, 8'h31); poke(8'h01, 8'h32); poke(8'h02, 8'd7);
        poke(8'h03, 8'd2); poke(8'h04, 8'h33); poke(8'h05, 8'h34); poke(8'h06, 8'h35); poke(8'h07, 8'd7);
        poke(8'h08, 8'd5); poke(8'h09, 8'h36); poke(8'h0A, 8'h36); poke(8'h0B, 8'h37); poke(8'h0C, 8'd7);
        poke(8'h30, 8'h7F); poke(8'h31, 8'h01); poke(8'h33, 8'h80); poke(8'h34, 8'h01); poke(8'h36, 8'h5A);
        poke(8'h37, 8'hFF);
        go();
        wait_halt(40, ok);
        chk("addovf_halt", 32'(ok), 32'd1);
        chk("addovf_result", 32'(mem[8'h32]), 32'h80);
        chk("addovf_flags", 32'({flag_zero, flag_ovf}), 32'b01);
        go();
        wait_halt(40, ok);
        chk("subovf_halt", 32'(ok), 32'd1);
        chk("subovf_result", 32'(mem[8'h35]), 32'h7F);
        chk("subovf_flags", 32'({flag_zero, flag_ovf}), 32'b01);
        go();
        wait_halt(40, ok);
        chk("xor_halt", 32'(ok), 32'd1);
        chk("xor_result", 32'(mem[8'h37]), 32'h00);
        chk("xor_flags", 32'({flag_zero, flag_ovf}), 32'b10);
        chk("xor_pc", 32'(dut.pc), 32'h0D);

        // same ADD under random wait states
        do_reset();
        wait_mode = 1'b1;
        poke(8'hFE, 8'd1); poke(8'hFF, 8'd10); poke(8'h00, 8'd11); poke(8'h01, 8'd12); poke(8'h02, 8'd7);
        poke(8'd10, 8'h05); poke(8'd11, 8'h03); poke(8'd12, 8'h00);
        go();
        wait_halt(200, ok);
        chk("wait_halt", 32'(ok), 32'd1);
        chk("wait_result", 32'(mem[12]), 32'h08);
        chk("wait_flags", 32'({flag_zero, flag_ovf}), 32'd0);
        chk("wait_stable", 32'(stab_err), 32'd0);
        chk("wait_stalls_seen", 32'(stab_cnt != 0), 32'd1);
        wait_mode = 1'b0;
        step();

        // JMP then HALT, restart from the word after HALT
        do_reset();
        poke(8'hFE, 8'd6); poke(8'hFF, 8'h20); poke(8'h20, 8'd7); poke(8'h21, 8'd0); poke(8'h22, 8'd7);
        go();
        step();
        step();
        chk("jmp_target_fetch", 32'(mem_addr), 32'h20);
        step();
        chk("jmp_halted", 32'(halted), 32'd1);
        chk("jmp_halt_pc", 32'(dut.pc), 32'h21);
        chk("jmp_halt_busy", 32'(busy), 32'd0);
        go();
        chk("restart_fetch", 32'(mem_addr), 32'h21);
        wait_halt(20, ok);
        chk("restart_halt", 32'(ok), 32'd1);
        chk("restart_pc", 32'(dut.pc), 32'h23);

        // pc wrap: NOP at FE, NOP at FF, HALT at 00
        do_reset();
        poke(8'hFE, 8'd0); poke(8'hFF, 8'd0); poke(8'h00, 8'd7);
        go();
        chk("wrap_fetch_fe", 32'(mem_addr), 32'hFE);
        step();
        chk("wrap_fetch_ff", 32'(mem_addr), 32'hFF);
        step();
        chk("wrap_fetch_00", 32'(mem_addr), 32'h00);
        step();
        chk("wrap_halted", 32'(halted), 32'd1);
        chk("wrap_pc", 32'(dut.pc), 32'h01);

        // reset while a STORE is stalled
        do_reset();
        poke(8'hFE, 8'd1); poke(8'hFF, 8'h30); poke(8'h00, 8'h31); poke(8'h01, 8'h32); poke(8'h02, 8'd7);
        poke(8'h30, 8'h7F); poke(8'h31, 8'h01); poke(8'h32, 8'hAA);
        we_block = 1'b1;
        go();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_we) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("mid_store_reached", 32'(ok), 32'd1);
        step();
        step();
        chk("mid_store_held", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 8'h32, 8'h80}));
        chk("mid_store_ovf", 32'(flag_ovf), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pc", 32'(dut.pc), 32'hFE);
        chk("mid_rst_flags", 32'({flag_zero, flag_ovf}), 32'd0);
        rst_n = 1'b1;
        we_block = 1'b0;
        step();
        chk("mid_rst_no_write", 32'(mem[8'h32]), 32'hAA);
        chk("mid_rst_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
